// File: rtl/inv_cipher_pkg.sv
// Shared AES inverse-cipher definitions: widths, FSM encodings, inverse S-box
// and the GF(2^8) constant multipliers used by InvMixColumns.
package inv_cipher_pkg;

  localparam int BLK_S = 128;
  localparam int KEY_S = 128;
  localparam int NB    = 4;

  typedef enum logic [1:0] {
    INV_IDLE  = 2'd0,
    INV_LOAD  = 2'd1,
    INV_ROUND = 2'd2
  } inv_state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] get_inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows -> InvSubBytes ->
// AddRoundKey -> InvMixColumns, with InvMixColumns bypassed on the last round.
module inv_round
  import inv_cipher_pkg::*;
(
  input  logic [BLK_S-1:0] i_state,
  input  logic [KEY_S-1:0] i_key,
  input  logic             i_last_round,
  output logic [BLK_S-1:0] o_state
);

  logic [BLK_S-1:0] w_sub;
  logic [BLK_S-1:0] w_mix;

  // Byte i of the shifted state comes from byte 13*i mod 16 (column-major layout).
  always_comb begin
    w_sub = '0;
    for (int i = 0; i < 16; i++) begin
      w_sub[8*i +: 8] = get_inv_sbox(i_state[8*((13*i)%16) +: 8]);
    end
    w_sub = w_sub ^ i_key;
  end

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[32*c +: 8]    = gm14(w_sub[32*c +: 8]) ^ gm11(w_sub[32*c+8 +: 8]) ^
                            gm13(w_sub[32*c+16 +: 8]) ^ gm9(w_sub[32*c+24 +: 8]);
      w_mix[32*c+8 +: 8]  = gm9(w_sub[32*c +: 8]) ^ gm14(w_sub[32*c+8 +: 8]) ^
                            gm11(w_sub[32*c+16 +: 8]) ^ gm13(w_sub[32*c+24 +: 8]);
      w_mix[32*c+16 +: 8] = gm13(w_sub[32*c +: 8]) ^ gm9(w_sub[32*c+8 +: 8]) ^
                            gm14(w_sub[32*c+16 +: 8]) ^ gm11(w_sub[32*c+24 +: 8]);
      w_mix[32*c+24 +: 8] = gm11(w_sub[32*c +: 8]) ^ gm13(w_sub[32*c+8 +: 8]) ^
                            gm9(w_sub[32*c+16 +: 8]) ^ gm14(w_sub[32*c+24 +: 8]);
    end
  end

  assign o_state = i_last_round ? w_sub : w_mix;

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES inverse cipher, one round per clock, round keys fetched Nr..0.
// Optional `INV_CIPHER_BUSY_EN adds a busy output; en while busy is ignored.
module inv_cipher
  import inv_cipher_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [BLK_S-1:0] ciphertext,
  input  logic [NB-1:0]    rounds_total,
  input  logic [KEY_S-1:0] key,
  output logic [BLK_S-1:0] plaintext,
  output logic [NB-1:0]    round_key_no,
  output logic             en_o
`ifdef INV_CIPHER_BUSY_EN
  ,
  output logic             busy
`endif
);

  localparam logic [NB-1:0] RND_ONE = NB'(1);

  inv_state_t       r_state;
  logic [BLK_S-1:0] r_ct;
  logic [BLK_S-1:0] r_blk;
  logic [BLK_S-1:0] r_pt;
  logic [NB-1:0]    r_nr;
  logic [NB-1:0]    r_rnd;
  logic [NB-1:0]    r_rkn;
  logic             r_en_o;
  logic [BLK_S-1:0] w_round_out;

  inv_round u_inv_round (
    .i_state      (r_blk),
    .i_key        (key),
    .i_last_round (r_rnd == '0),
    .o_state      (w_round_out)
  );

  // en is only looked at in IDLE, so a request during a block is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INV_IDLE;
      r_ct    <= '0;
      r_blk   <= '0;
      r_pt    <= '0;
      r_nr    <= '0;
      r_rnd   <= '0;
      r_rkn   <= '0;
      r_en_o  <= 1'b0;
    end else begin
      r_en_o <= 1'b0;
      case (r_state)
        INV_IDLE: begin
          if (en) begin
            r_ct    <= ciphertext;
            r_nr    <= rounds_total;
            r_rkn   <= rounds_total;
            r_state <= INV_LOAD;
          end
        end
        INV_LOAD: begin
          r_rkn   <= r_nr - RND_ONE;
          r_rnd   <= r_nr;
          r_state <= INV_ROUND;
        end
        INV_ROUND: begin
          if (r_rkn != '0) r_rkn <= r_rkn - RND_ONE;
          if (r_rnd != '0) r_rnd <= r_rnd - RND_ONE;
          if (r_rnd == r_nr) begin
            r_blk <= r_ct ^ key;
          end else if (r_rnd != '0) begin
            r_blk <= w_round_out;
          end else begin
            r_pt    <= w_round_out;
            r_en_o  <= 1'b1;
            r_state <= INV_IDLE;
          end
        end
        default: r_state <= INV_IDLE;
      endcase
    end
  end

  assign plaintext    = r_pt;
  assign round_key_no = r_rkn;
  assign en_o         = r_en_o;
`ifdef INV_CIPHER_BUSY_EN
  assign busy         = (r_state != INV_IDLE);
`endif

endmodule

// File: tb/tb_inv_cipher.sv
// Directed bench for inv_cipher: FIPS-197 vectors for AES-128/192/256 with a
// 1-cycle key store built from its own key expansion.
module tb_inv_cipher;

  logic         clk;
  logic         reset;
  logic         en;
  logic [127:0] ciphertext;
  logic [3:0]   rounds_total;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [3:0]   round_key_no;
  logic         en_o;
`ifdef INV_CIPHER_BUSY_EN
  logic         busy;
`endif

  int n_vec;
  int n_miss;
  int cyc;
  int cur_nr;

  logic [127:0] rk [15];

  localparam logic [127:0] PT_F    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128_F = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192_F = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256_F = 128'h8ea2b7ca516745bfeafc49904b496089;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  inv_cipher dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .ciphertext   (ciphertext),
    .rounds_total (rounds_total),
    .key          (key),
    .plaintext    (plaintext),
    .round_key_no (round_key_no),
    .en_o         (en_o)
`ifdef INV_CIPHER_BUSY_EN
    ,
    .busy         (busy)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key store: one-cycle read latency
  always @(posedge clk) key <= rk[round_key_no];

  // FIPS hex (first byte leftmost) -> byte n at [8n+:8]
  function automatic logic [127:0] fips(input logic [127:0] h);
    logic [127:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = h[8*(15-n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = SBOX[w[8*j +: 8]];
    return r;
  endfunction

  // Key bytes 00,01,02,... ; nk = 4/6/8 words.
  task automatic expand_key(input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[7:0], t[31:8]});
        t[7:0] = t[7:0] ^ rcon;
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++) begin
      rk[r] = (r <= nr) ? {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]} : '0;
    end
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver: one-cycle en pulse; inputs scrambled afterwards
  task automatic launch(input logic [127:0] ct_f, input int nr);
    en           = 1'b1;
    ciphertext   = fips(ct_f);
    rounds_total = 4'(nr);
    cur_nr       = nr;
    @(negedge clk);
    en           = 1'b0;
    ciphertext   = {$urandom, $urandom, $urandom, $urandom};
    rounds_total = 4'($urandom_range(2, 14));
    cyc          = 1;
  endtask

  // Follows one block up to its en_o cycle, checking key addresses on the way.
  task automatic wait_done(input string tag, input logic [127:0] exp_pt, input int exp_lat,
                           input logic [127:0] prev_pt);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (cyc <= cur_nr + 2)
        chk({tag, "_rkn"}, 128'(round_key_no), 128'((cyc <= cur_nr + 1) ? cur_nr - cyc + 1 : 0));
      if (cyc == exp_lat - 1) chk({tag, "_hold"}, plaintext, prev_pt);
      if (en_o === 1'b1) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({tag, "_lat"}, 128'(cyc), 128'(exp_lat));
    chk({tag, "_pt"}, plaintext, exp_pt);
  endtask

  task automatic count_pulses(input string tag, input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (en_o === 1'b1) cnt++;
    end
    chk(tag, 128'(cnt), 128'(0));
  endtask

  initial begin
    n_vec        = 0;
    n_miss       = 0;
    cyc          = 0;
    cur_nr       = 10;
    reset        = 1'b1;
    en           = 1'b0;
    ciphertext   = '0;
    rounds_total = '0;
    expand_key(4);
    repeat (3) @(negedge clk);
    chk("rst_pt", plaintext, '0);
    chk("rst_rkn", 128'(round_key_no), 128'(0));
    chk("rst_en_o", 128'(en_o), 128'(0));
`ifdef INV_CIPHER_BUSY_EN
    chk("rst_busy", 128'(busy), 128'(0));
`endif
    reset = 1'b0;
    @(negedge clk);

    // AES-128
    launch(CT128_F, 10);
    wait_done("aes128", fips(PT_F), 13, '0);
    @(negedge clk);
    chk("aes128_pulse", 128'(en_o), 128'(0));
    chk("aes128_held", plaintext, fips(PT_F));

    // AES-192
    expand_key(6);
    launch(CT192_F, 12);
    wait_done("aes192", fips(PT_F), 15, fips(PT_F));
    @(negedge clk);

    // AES-256
    expand_key(8);
    launch(CT256_F, 14);
    wait_done("aes256", fips(PT_F), 17, fips(PT_F));
    @(negedge clk);

    // back-to-back: second en in the en_o cycle
    expand_key(4);
    launch(CT128_F, 10);
    wait_done("b2b_1", fips(PT_F), 13, fips(PT_F));
    launch(CT128_F, 10);
    wait_done("b2b_2", fips(PT_F), 13, fips(PT_F));
    @(negedge clk);
    chk("b2b_pulse", 128'(en_o), 128'(0));

    // reset in cycle 6 aborts the block
    launch(CT128_F, 10);
    while (cyc < 6) begin
      @(negedge clk);
      cyc++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_pt", plaintext, '0);
    chk("abort_rkn", 128'(round_key_no), 128'(0));
    chk("abort_en_o", 128'(en_o), 128'(0));
    count_pulses("abort_no_pulse", 20);
    launch(CT128_F, 10);
    wait_done("after_rst", fips(PT_F), 13, '0);
    @(negedge clk);

`ifdef INV_CIPHER_BUSY_EN
    // en while busy is dropped
    launch(CT128_F, 10);
    while (cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_hi", 128'(busy), 128'(1));
    en           = 1'b1;
    ciphertext   = fips(CT192_F);
    rounds_total = 4'd12;
    @(negedge clk);
    cyc++;
    en = 1'b0;
    wait_done("busy_ign", fips(PT_F), 13, fips(PT_F));
    @(negedge clk);
    chk("busy_lo", 128'(busy), 128'(0));
    count_pulses("busy_single_pulse", 20);
    chk("busy_pt_kept", plaintext, fips(PT_F));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
